// File: rtl/jelly3_axi4l_register_bank.sv
// AXI4-Lite register bank: REG_NUM control/status words behind one slave port.
// Write AW/W are buffered independently; reads are single-outstanding.

module jelly3_axi4l_register_bank_lane #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    STRB_WIDTH = DATA_WIDTH/8,
  parameter logic [DATA_WIDTH-1:0] INIT       = '0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  wr
);
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      q  <= INIT;
      wr <= 1'b0;
    end else begin
      wr <= we;
      if (we) begin
        for (int b = 0; b < STRB_WIDTH; b++) begin
          if (wstrb[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end
endmodule

module jelly3_axi4l_register_bank #(
  parameter int                             ADDR_WIDTH = 32,
  parameter int                             DATA_WIDTH = 32,
  parameter int                             STRB_WIDTH = DATA_WIDTH/8,
  parameter int                             REG_NUM    = 8,
  parameter logic [REG_NUM*DATA_WIDTH-1:0]  INIT_VALUE = '0,
  parameter logic [REG_NUM-1:0]             RO_MASK    = '0
) (
  input  logic                               aresetn,
  input  logic                               aclk,
  input  logic [ADDR_WIDTH-1:0]              s_awaddr,
  input  logic [2:0]                         s_awprot,
  input  logic                               s_awvalid,
  output logic                               s_awready,
  input  logic [DATA_WIDTH-1:0]              s_wdata,
  input  logic [STRB_WIDTH-1:0]              s_wstrb,
  input  logic                               s_wvalid,
  output logic                               s_wready,
  output logic [1:0]                         s_bresp,
  output logic                               s_bvalid,
  input  logic                               s_bready,
  input  logic [ADDR_WIDTH-1:0]              s_araddr,
  input  logic [2:0]                         s_arprot,
  input  logic                               s_arvalid,
  output logic                               s_arready,
  output logic [DATA_WIDTH-1:0]              s_rdata,
  output logic [1:0]                         s_rresp,
  output logic                               s_rvalid,
  input  logic                               s_rready,
  input  logic [REG_NUM-1:0][DATA_WIDTH-1:0] status_in,
  output logic [REG_NUM-1:0][DATA_WIDTH-1:0] reg_out,
  output logic [REG_NUM-1:0]                 reg_wr
);
  localparam int         ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int         IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam logic [1:0] OKAY     = 2'b00;
  localparam logic [1:0] SLVERR   = 2'b10;

  logic                  aw_held, w_held, commit, aw_hit, ar_hit;
  logic [IDX_W-1:0]      aw_idx, ar_idx;
  logic [DATA_WIDTH-1:0] w_data, rd_sel;
  logic [STRB_WIDTH-1:0] w_strb;
  logic [REG_NUM-1:0]    lane_we;
  logic                  unused_ok;

  assign unused_ok = &{1'b0, s_awprot, s_arprot, s_awaddr, s_araddr};

  assign s_awready = !aw_held;
  assign s_wready  = !w_held;
  assign s_arready = !s_rvalid;
  assign commit    = aw_held && w_held && !s_bvalid;
  assign aw_hit    = aw_idx < IDX_W'(REG_NUM);
  assign ar_idx    = s_araddr[ADDR_WIDTH-1:ADDR_LSB];
  assign ar_hit    = ar_idx < IDX_W'(REG_NUM);

  // Write side: one-entry AW and W holds, commit only once B has drained.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx   <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      s_bvalid <= 1'b0;
      s_bresp  <= OKAY;
    end else begin
      if (s_awvalid && s_awready) begin
        aw_held <= 1'b1;
        aw_idx  <= s_awaddr[ADDR_WIDTH-1:ADDR_LSB];
      end else if (commit) begin
        aw_held <= 1'b0;
      end
      if (s_wvalid && s_wready) begin
        w_held <= 1'b1;
        w_data <= s_wdata;
        w_strb <= s_wstrb;
      end else if (commit) begin
        w_held <= 1'b0;
      end
      if (commit) begin
        s_bvalid <= 1'b1;
        s_bresp  <= aw_hit ? OKAY : SLVERR;
      end else if (s_bready) begin
        s_bvalid <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < REG_NUM; gi++) begin : g_lane
      assign lane_we[gi] = commit && !RO_MASK[gi] && (aw_idx == IDX_W'(gi));
      jelly3_axi4l_register_bank_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH),
        .INIT       (INIT_VALUE[gi*DATA_WIDTH +: DATA_WIDTH])
      ) u_lane (
        .aclk    (aclk),
        .aresetn (aresetn),
        .we      (lane_we[gi]),
        .wdata   (w_data),
        .wstrb   (w_strb),
        .q       (reg_out[gi]),
        .wr      (reg_wr[gi])
      );
    end
  endgenerate

  // Read mux samples the flops, so a same-edge write commit is not yet visible.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (ar_idx == IDX_W'(i)) rd_sel = RO_MASK[i] ? status_in[i] : reg_out[i];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= OKAY;
    end else if (s_arvalid && s_arready) begin
      s_rvalid <= 1'b1;
      s_rdata  <= rd_sel;
      s_rresp  <= ar_hit ? OKAY : SLVERR;
    end else if (s_rready) begin
      s_rvalid <= 1'b0;
    end
  end
endmodule
